// File: rtl/eoc_hang_reporter.sv
// ---------------------------------------------------------------------------
// eoc_hang_reporter
//
// Produces the 32-bit end-of-computation (EOC) word polled by the simulation
// harness: bit 0 = done, bits [31:1] = exit code. Software sets the word with
// a write. An optional commit-PC watchdog forces a failure code when the core
// stops making progress, so a hung core still ends the run with a known code.
//
// Build option:
//   EOC_HANG_WATCHDOG_EN  defined   -> commit-PC hang watchdog is built
//                         undefined -> software-only EOC register; hang_o and
//                                      hang_pc_o are tied to 0 and the commit
//                                      inputs are ignored
//
// Parameters:
//   MaxCycles     consecutive cycles with an unchanged commit PC that count
//                 as a hang (must be >= 2)
//   PcWidth       commit PC width
//   HangExitCode  31-bit exit code reported on a hang
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   clear_i          synchronous clear back to the reset state (top priority)
//   commit_valid_i   core committed an instruction this cycle
//   commit_pc_i      commit-stage PC, sampled every cycle
//   sw_eoc_valid_i   software write request
//   sw_eoc_data_i    software EOC word
//   sw_eoc_ready_o   write accept (decoded from state: high unless DONE)
//   eoc_q_o          current EOC word
//   eoc_valid_o      one-cycle pulse when the done bit first becomes 1
//   hang_o           hang detected, sticky until clear or reset
//   hang_pc_o        PC at which the hang was detected
//
// State table:
//   state | meaning
//   IDLE  | after reset or clear; no commit seen yet, watchdog not armed
//   RUN   | first commit seen; watchdog counting unchanged-PC cycles
//   DONE  | done bit set; absorbing until clear or reset
// ---------------------------------------------------------------------------
module eoc_hang_reporter #(
  parameter int unsigned MaxCycles    = 10000,
  parameter int unsigned PcWidth      = 64,
  parameter logic [30:0] HangExitCode = 31'h7EAD
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               commit_valid_i,
  input  logic [PcWidth-1:0] commit_pc_i,
  input  logic               sw_eoc_valid_i,
  input  logic [31:0]        sw_eoc_data_i,
  output logic               sw_eoc_ready_o,
  output logic [31:0]        eoc_q_o,
  output logic               eoc_valid_o,
  output logic               hang_o,
  output logic [PcWidth-1:0] hang_pc_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] eoc_q, eoc_d;
  logic        eoc_valid_q, eoc_valid_d;
  logic        sw_accept;
  logic        sw_done;

  assign sw_eoc_ready_o = (state_q != ST_DONE);
  assign sw_accept      = sw_eoc_valid_i && sw_eoc_ready_o;
  assign sw_done        = sw_accept && sw_eoc_data_i[0];

`ifdef EOC_HANG_WATCHDOG_EN
  localparam int unsigned      CntW    = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(MaxCycles - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(MaxCycles);

  logic [CntW-1:0]    count_q, count_d;
  logic [PcWidth-1:0] last_pc_q, last_pc_d;
  logic               hang_q, hang_d;
  logic [PcWidth-1:0] hang_pc_q, hang_pc_d;
  logic               pc_same;
  logic               hang_hit;

  assign pc_same  = (commit_pc_i == last_pc_q);
  // count holds the number of edges since the last PC change minus one, so
  // matching MaxCycles-1 with the PC still unchanged fires on edge
  // E+MaxCycles after the change registered at edge E.
  assign hang_hit = (state_q == ST_RUN) && pc_same && (count_q == CntLast);
`endif

  always_comb begin
    state_d     = state_q;
    eoc_d       = eoc_q;
    eoc_valid_d = 1'b0;
`ifdef EOC_HANG_WATCHDOG_EN
    count_d     = count_q;
    last_pc_d   = last_pc_q;
    hang_d      = hang_q;
    hang_pc_d   = hang_pc_q;
`endif

    if (clear_i) begin
      state_d = ST_IDLE;
      eoc_d   = '0;
`ifdef EOC_HANG_WATCHDOG_EN
      count_d   = '0;
      last_pc_d = '0;
      hang_d    = 1'b0;
      hang_pc_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (sw_accept) begin
            eoc_d = sw_eoc_data_i;
          end

          // A software done write beats a hang on the same edge; a write with
          // the done bit clear does not, and the hang word overwrites it.
          if (sw_done) begin
            state_d     = ST_DONE;
            eoc_valid_d = 1'b1;
          end
`ifdef EOC_HANG_WATCHDOG_EN
          else if (hang_hit) begin
            state_d     = ST_DONE;
            eoc_valid_d = 1'b1;
            eoc_d       = {HangExitCode, 1'b1};
            hang_d      = 1'b1;
            hang_pc_d   = last_pc_q;
          end else if ((state_q == ST_IDLE) && commit_valid_i) begin
            state_d   = ST_RUN;
            last_pc_d = commit_pc_i;
            count_d   = '0;
          end

          if (state_q == ST_RUN) begin
            if (!pc_same) begin
              last_pc_d = commit_pc_i;
              count_d   = '0;
            end else if (count_q != CntMax) begin
              count_d = count_q + 1'b1;
            end
          end
`endif
        end

        ST_DONE: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      eoc_q       <= '0;
      eoc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      eoc_q       <= eoc_d;
      eoc_valid_q <= eoc_valid_d;
    end
  end

  assign eoc_q_o     = eoc_q;
  assign eoc_valid_o = eoc_valid_q;

`ifdef EOC_HANG_WATCHDOG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      last_pc_q <= '0;
      hang_q    <= 1'b0;
      hang_pc_q <= '0;
    end else begin
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
      hang_q    <= hang_d;
      hang_pc_q <= hang_pc_d;
    end
  end

  assign hang_o    = hang_q;
  assign hang_pc_o = hang_pc_q;
`else
  // Commit inputs have no consumer without the watchdog.
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_pc_i};

  assign hang_o    = 1'b0;
  assign hang_pc_o = '0;
`endif

endmodule

// File: tb/tb_eoc_hang_reporter.sv
module tb_eoc_hang_reporter;

  localparam int unsigned PcW = 64;
`ifdef EOC_HANG_WATCHDOG_EN
  localparam bit Wd = 1'b1;
`else
  localparam bit Wd = 1'b0;
`endif

  localparam logic [63:0] PcA      = 64'h8000_0000;
  localparam logic [63:0] PcB      = 64'h8000_0100;
  localparam logic [63:0] PcC      = 64'h8000_0200;
  localparam logic [31:0] HangWord = 32'h0000_FD5B;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           clear_i;
  logic           commit_valid_i;
  logic [PcW-1:0] commit_pc_i;
  logic           sw_eoc_valid_i;
  logic [31:0]    sw_eoc_data_i;
  logic           sw_eoc_ready_o;
  logic [31:0]    eoc_q_o;
  logic           eoc_valid_o;
  logic           hang_o;
  logic [PcW-1:0] hang_pc_o;

  int n_vec = 0;
  int n_err = 0;

  eoc_hang_reporter #(
    .MaxCycles   (16),
    .PcWidth     (PcW),
    .HangExitCode(31'h7EAD)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .commit_valid_i(commit_valid_i),
    .commit_pc_i   (commit_pc_i),
    .sw_eoc_valid_i(sw_eoc_valid_i),
    .sw_eoc_data_i (sw_eoc_data_i),
    .sw_eoc_ready_o(sw_eoc_ready_o),
    .eoc_q_o       (eoc_q_o),
    .eoc_valid_o   (eoc_valid_o),
    .hang_o        (hang_o),
    .hang_pc_o     (hang_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n active edges; inputs are driven and outputs sampled 1 ns later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_eoc"},   64'(eoc_q_o),        64'h0);
    chk({tag, "_valid"}, 64'(eoc_valid_o),    64'h0);
    chk({tag, "_hang"},  64'(hang_o),         64'h0);
    chk({tag, "_hpc"},   hang_pc_o,           64'h0);
    chk({tag, "_ready"}, 64'(sw_eoc_ready_o), 64'h1);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic sw_write(input logic [31:0] d);
    sw_eoc_valid_i = 1'b1;
    sw_eoc_data_i  = d;
    step();
    sw_eoc_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; commit_valid_i = 1'b0; commit_pc_i = '0;
    sw_eoc_valid_i = 1'b0; sw_eoc_data_i = '0;
    #12;
    chk_reset_vals("rst");
    rst_ni = 1'b1;
    step();

    // Software pass
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_valid_i = 1'b0;
    sw_write(32'h1);
    chk("pass_eoc",   64'(eoc_q_o),        64'h1);
    chk("pass_valid", 64'(eoc_valid_o),    64'h1);
    chk("pass_ready", 64'(sw_eoc_ready_o), 64'h0);
    chk("pass_hang",  64'(hang_o),         64'h0);
    step();
    chk("pass_pulse", 64'(eoc_valid_o),    64'h0);
    chk("pass_hold",  64'(eoc_q_o),        64'h1);

    do_clear();
    chk_reset_vals("clr1");

    // Software fail, then a second write is locked out
    sw_write(32'h7);
    chk("fail_eoc",   64'(eoc_q_o),        64'h7);
    chk("fail_valid", 64'(eoc_valid_o),    64'h1);
    sw_write(32'h1);
    chk("lock_eoc",   64'(eoc_q_o),        64'h7);
    chk("lock_valid", 64'(eoc_valid_o),    64'h0);
    chk("lock_ready", 64'(sw_eoc_ready_o), 64'h0);

    do_clear();

    // Hang: PC changes once then holds; detection 16 edges after the change
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_pc_i = PcB;
    step();
    commit_valid_i = 1'b0;
    step(15);
    chk("hang_early", 64'(hang_o), 64'h0);
    step();
    chk("hang_flag",  64'(hang_o),         Wd ? 64'h1 : 64'h0);
    chk("hang_eoc",   64'(eoc_q_o),        Wd ? 64'(HangWord) : 64'h0);
    chk("hang_pc",    hang_pc_o,           Wd ? PcB : 64'h0);
    chk("hang_valid", 64'(eoc_valid_o),    Wd ? 64'h1 : 64'h0);
    chk("hang_ready", 64'(sw_eoc_ready_o), Wd ? 64'h0 : 64'h1);
    step();
    chk("hang_pulse", 64'(eoc_valid_o),    64'h0);

    do_clear();
    chk_reset_vals("clr2");

    // PC changes at cycle 15: counter restarts, hang moves 15 edges later
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_pc_i = PcB;
    step();
    commit_valid_i = 1'b0;
    step(14);
    commit_pc_i = PcC;
    step();
    step();
    chk("restart_nohang", 64'(hang_o), 64'h0);
    step(14);
    chk("restart_early",  64'(hang_o), 64'h0);
    step();
    chk("restart_hang",   64'(hang_o), Wd ? 64'h1 : 64'h0);
    chk("restart_pc",     hang_pc_o,   Wd ? PcC : 64'h0);

    do_clear();

    // Software done write on the hang-detect edge wins
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_valid_i = 1'b0;
    step(15);
    sw_write(32'h5);
    chk("simul_eoc",   64'(eoc_q_o),     64'h5);
    chk("simul_hang",  64'(hang_o),      64'h0);
    chk("simul_valid", 64'(eoc_valid_o), 64'h1);

    do_clear();

    // Non-done write keeps RUN and is overwritten by the hang word
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_valid_i = 1'b0;
    step(9);
    sw_write(32'h4);
    chk("nd_eoc",   64'(eoc_q_o),        64'h4);
    chk("nd_ready", 64'(sw_eoc_ready_o), 64'h1);
    chk("nd_valid", 64'(eoc_valid_o),    64'h0);
    step(5);
    sw_write(32'h4);
    chk("nd_hang_eoc", 64'(eoc_q_o), Wd ? 64'(HangWord) : 64'h4);
    chk("nd_hang",     64'(hang_o),  Wd ? 64'h1 : 64'h0);

    do_clear();

    // IDLE gating: constant PC without any commit never arms the watchdog
    commit_valid_i = 1'b0; commit_pc_i = PcB;
    step(100);
    chk_reset_vals("idle");

    // Reset mid-count drops a pending write; block re-arms afterwards
    commit_valid_i = 1'b1; commit_pc_i = PcA;
    step();
    commit_valid_i = 1'b0;
    step(5);
    sw_write(32'h6);
    chk("rst_pre_eoc", 64'(eoc_q_o), 64'h6);
    sw_eoc_valid_i = 1'b1; sw_eoc_data_i = 32'h3;
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_vals("async");
    sw_eoc_valid_i = 1'b0;
    #2 rst_ni = 1'b1;
    step();
    chk("rst_drop_eoc", 64'(eoc_q_o), 64'h0);
    commit_valid_i = 1'b1; commit_pc_i = PcB;
    step();
    commit_valid_i = 1'b0;
    step(15);
    chk("rearm_early", 64'(hang_o), 64'h0);
    step();
    chk("rearm_hang",  64'(hang_o), Wd ? 64'h1 : 64'h0);
    chk("rearm_pc",    hang_pc_o,   Wd ? PcB : 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eoc_hang_reporter.md
# eoc_hang_reporter

In-SoC producer of the 32-bit end-of-computation (EOC) word, in the format the simulation harness polls: bit 0 = done, bits [31:1] = exit code. The word is set either by a software write (scratch-style) or by a hardware commit-PC hang watchdog that forces a failure code. It sits beside the core's commit stage and the register file, so a hung core still terminates simulation or FPGA runs with a defined exit code.

## Interface
- `MaxCycles`, default 10000: consecutive cycles with an unchanged commit PC that count as a hang. Must be ≥ 2.
- `PcWidth`, default 64: commit PC width.
- `HangExitCode`, default 31'h7EAD: exit code reported on a hang, 31 bits.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear back to the reset state.
- `commit_valid_i` in 1: core committed an instruction this cycle.
- `commit_pc_i` in PcWidth: commit-stage PC, sampled every cycle.
- `sw_eoc_valid_i` in 1: software write request.
- `sw_eoc_data_i` in 32: software EOC word.
- `sw_eoc_ready_o` out 1: write accept.
- `eoc_q_o` out 32: current EOC word.
- `eoc_valid_o` out 1: one-cycle pulse when the done bit first becomes 1.
- `hang_o` out 1: hang detected (sticky until clear or reset).
- `hang_pc_o` out PcWidth: PC at which the hang was detected.

## Operation
- **States:**
  - IDLE: after reset or clear.
  - RUN: after the first commit.
  - DONE: EOC done bit set.
- **IDLE → RUN:** first cycle with `commit_valid_i`=1. `last_pc` is loaded with `commit_pc_i` and `count` is set to 0.
- **RUN, each cycle:**
  - If `commit_pc_i` != `last_pc`: load `last_pc` and set `count` to 0.
  - Otherwise `count` += 1.
  - `count` is `$clog2(MaxCycles+1)` bits wide and never wraps.
- **Hang:** in RUN, when `count` = MaxCycles-1 and the PC is unchanged, at that edge:
  - `eoc_q_o` becomes {HangExitCode, 1'b1}.
  - `hang_o` becomes 1.
  - `hang_pc_o` becomes `last_pc`.
  - State moves to DONE.
- **Software write:** accepted when `sw_eoc_valid_i` && `sw_eoc_ready_o`.
  - `sw_eoc_ready_o` = 1 in IDLE and RUN, 0 in DONE.
  - Accepted data is written to `eoc_q_o`.
  - If data[0]=1, state moves to DONE. A write with data[0]=0 only updates the word; the state is unchanged.
- **Simultaneous software done write and hang in the same cycle:** software wins. `eoc_q_o` takes the software data and `hang_o` stays 0.
- **DONE:** absorbing. The counter is frozen and writes are not accepted. Only `clear_i` or reset leaves DONE.
- **`clear_i`:** has priority over all other events. It returns the block to the reset values and the IDLE state.

## Timing
- **Reset / clear values:**
  - `eoc_q_o`=0, `eoc_valid_o`=0, `hang_o`=0, `hang_pc_o`=0.
  - `sw_eoc_ready_o`=1, state=IDLE, `count`=0, `last_pc`=0.
- **Software write latency:** a write accepted at edge N is visible on `eoc_q_o` after edge N. `eoc_valid_o` is high for exactly the cycle after edge N when data[0]=1.
- **Hang latency:** if the last PC change is registered at edge E, `hang_o` and `eoc_q_o` update at edge E+MaxCycles. `eoc_valid_o` pulses for one cycle after that edge.
- **Pipelining:** all outputs are registered; there is no combinational input-to-output path except `sw_eoc_ready_o`, which is decoded from the state register.
- **Asynchronous reset mid-operation:** immediate return to the reset values. A pending write is dropped.

## Configuration
- **`EOC_HANG_WATCHDOG_EN` defined:** the watchdog is built as described above.
- **`EOC_HANG_WATCHDOG_EN` undefined:**
  - `count`, `last_pc` and the hang logic are not instantiated.
  - `hang_o` and `hang_pc_o` are tied to 0.
  - The IDLE/RUN distinction is kept, but only a software done write can reach DONE.
  - `commit_valid_i` and `commit_pc_i` are unused.

## Test plan
All scenarios use MaxCycles=16, HangExitCode=31'h7EAD.
- **Software pass:** commit at PC 0x8000_0000, then write 0x0000_0001 → `eoc_q_o`=0x1 one cycle later, `eoc_valid_o` pulses once, `sw_eoc_ready_o`=0, `hang_o`=0.
- **Software fail and locking:** write 0x0000_0007 (exit code 3), then write 0x1 → `eoc_q_o` stays 0x7 and the second write is not accepted.
- **Hang:**
  - Hold PC 0x8000_0100 after one change.
  - Expect `hang_o`=1 exactly 16 edges later, `eoc_q_o`=0x0000_FD5B and `hang_pc_o`=0x8000_0100.
  - Same sequence with the PC changing at cycle 15 → no hang, count restarts.
- **Simultaneous events:**
  - Software write 0x5 on the hang-detect cycle → `eoc_q_o`=0x5, `hang_o`=0.
  - Data 0x4 (done bit clear) → state stays RUN and the `eoc_q_o`=0x4 write is overwritten by the hang word.
- **IDLE gating:** constant PC with `commit_valid_i`=0 for 100 cycles → no hang and state stays IDLE.
- **Clear and reset:** `clear_i` in DONE, then assert `rst_ni` low mid-count → all outputs return to their reset values within 1 cycle (clear) or immediately (reset). After release, the block re-arms on the next commit.
